// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//   MEM pipeline stage. It takes the EX result and the active-low data-memory
//   strobes, then performs a word load or store on an internal synchronous
//   data memory. The access can take WAIT_STATES extra cycles. The stage
//   registers the MEM/WB result for writeback and holds upstream with Stall.
//
//   Optional build feature: define MISALIGN_CHECK_EN to detect misaligned
//   memory ops. When it is undefined, ALUResult[1:0] plays no part in
//   addressing and MisalignErr is tied to 0.
// -----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int ADDR_W      = 10,   // word-address width
    parameter int WAIT_STATES = 0     // extra cycles per memory access (0..15)
) (
    input  logic        CLK,
    input  logic        RSTB,
    input  logic        InValid,
    input  logic        Dmem1ALUOUT,
    input  logic        DmemREB,
    input  logic        DmemWEB,
    input  logic [31:0] ALUResult,
    input  logic [31:0] StoreData,
    input  logic [4:0]  RdAddr,
    input  logic        RegWriteIn,
    output logic        Stall,
    output logic        WbValid,
    output logic [31:0] WbData,
    output logic [4:0]  WbRdAddr,
    output logic        WbRegWrite,
    output logic        MisalignErr
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);
    localparam bit         NO_WAIT  = (WAIT_STATES == 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // FSM and wait counter
    state_t      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;

    // Latched copy of a multi-cycle memory op (live inputs may change meanwhile)
    logic [31:0] op_alu_q,   op_alu_d;
    logic [31:0] op_wdata_q, op_wdata_d;
    logic [4:0]  op_rd_q,    op_rd_d;
    logic        op_regwr_q, op_regwr_d;
    logic        op_load_q,  op_load_d;
    logic        op_store_q, op_store_d;
    logic        op_mis_q,   op_mis_d;

    // Registered outputs
    logic        stall_q,    stall_d;
    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_data_q,  wb_data_d;
    logic [4:0]  wb_rd_q,    wb_rd_d;
    logic        wb_regwr_q, wb_regwr_d;
    logic        mis_err_q,  mis_err_d;

    // Data memory (never reset)
    logic [31:0] mem_q [DEPTH];

    // Input decode and completion-source selection
    logic              accept_s;
    logic              in_store_s;
    logic              in_load_s;
    logic              in_mem_s;
    logic              in_mis_s;
    logic              cmp_fire_s;
    logic [31:0]       cmp_alu_s;
    logic [31:0]       cmp_wdata_s;
    logic [4:0]        cmp_rd_s;
    logic              cmp_regwr_s;
    logic              cmp_load_s;
    logic              cmp_store_s;
    logic              cmp_mis_s;
    logic [ADDR_W-1:0] cmp_waddr_s;
    logic [31:0]       mem_rdata_s;
    logic              mem_we_s;

    // Classify the incoming op. Strobes are honoured only when the control
    // unit marks the instruction as a memory op; a store wins when both
    // strobes are low.
    always_comb begin
        accept_s   = InValid & ~stall_q & (state_q == ST_IDLE);
        in_store_s = Dmem1ALUOUT & ~DmemWEB;
        in_load_s  = Dmem1ALUOUT & ~DmemREB & DmemWEB;
        in_mem_s   = in_store_s | in_load_s;
`ifdef MISALIGN_CHECK_EN
        in_mis_s   = in_mem_s & (ALUResult[1:0] != 2'b00);
`else
        in_mis_s   = 1'b0;
`endif
    end

    // Pick the op completing this edge: the latched copy in DONE, otherwise
    // the live inputs (single-cycle path: non-memory ops, or no wait states).
    always_comb begin
        if (state_q == ST_DONE) begin
            cmp_fire_s  = 1'b1;
            cmp_alu_s   = op_alu_q;
            cmp_wdata_s = op_wdata_q;
            cmp_rd_s    = op_rd_q;
            cmp_regwr_s = op_regwr_q;
            cmp_load_s  = op_load_q;
            cmp_store_s = op_store_q;
            cmp_mis_s   = op_mis_q;
        end else begin
            cmp_fire_s  = accept_s & (~in_mem_s | NO_WAIT);
            cmp_alu_s   = ALUResult;
            cmp_wdata_s = StoreData;
            cmp_rd_s    = RdAddr;
            cmp_regwr_s = RegWriteIn;
            cmp_load_s  = in_load_s;
            cmp_store_s = in_store_s;
            cmp_mis_s   = in_mis_s;
        end
        cmp_waddr_s = cmp_alu_s[ADDR_W+1:2];
        mem_rdata_s = mem_q[cmp_waddr_s];
        // The write happens exactly once, on the completion edge, and never
        // while reset is held.
        mem_we_s    = cmp_fire_s & cmp_store_s & ~cmp_mis_s & RSTB;
    end

    // Next-state logic for the access FSM, the wait counter and the op latch
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_alu_d   = op_alu_q;
        op_wdata_d = op_wdata_q;
        op_rd_d    = op_rd_q;
        op_regwr_d = op_regwr_q;
        op_load_d  = op_load_q;
        op_store_d = op_store_q;
        op_mis_d   = op_mis_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && in_mem_s && !NO_WAIT) begin
                    op_alu_d   = ALUResult;
                    op_wdata_d = StoreData;
                    op_rd_d    = RdAddr;
                    op_regwr_d = RegWriteIn;
                    op_load_d  = in_load_s;
                    op_store_d = in_store_s;
                    op_mis_d   = in_mis_s;
                    cnt_d      = WAIT_CNT;
                    // A single wait state is spent entirely in DONE.
                    if (WAIT_CNT == 4'd1) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // Counter reaching 1 hands over to DONE.
                if (cnt_q == 4'd2) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                cnt_d   = 4'd0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered MEM/WB outputs and Stall
    always_comb begin
        stall_d    = (state_d != ST_IDLE);
        wb_valid_d = cmp_fire_s;
        mis_err_d  = cmp_fire_s & cmp_mis_s;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_regwr_d = wb_regwr_q;
        if (cmp_fire_s) begin
            wb_rd_d = cmp_rd_s;
            if (cmp_mis_s) begin
                wb_data_d  = cmp_alu_s;
                wb_regwr_d = 1'b0;
            end else if (cmp_store_s) begin
                wb_data_d  = cmp_alu_s;
                wb_regwr_d = 1'b0;
            end else if (cmp_load_s) begin
                wb_data_d  = mem_rdata_s;
                wb_regwr_d = cmp_regwr_s;
            end else begin
                wb_data_d  = cmp_alu_s;
                wb_regwr_d = cmp_regwr_s;
            end
        end else begin
            wb_rd_d = wb_rd_q;
        end
    end

    // State, latch and output registers with asynchronous active-low reset
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            op_alu_q   <= 32'd0;
            op_wdata_q <= 32'd0;
            op_rd_q    <= 5'd0;
            op_regwr_q <= 1'b0;
            op_load_q  <= 1'b0;
            op_store_q <= 1'b0;
            op_mis_q   <= 1'b0;
            stall_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= 32'd0;
            wb_rd_q    <= 5'd0;
            wb_regwr_q <= 1'b0;
            mis_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_alu_q   <= op_alu_d;
            op_wdata_q <= op_wdata_d;
            op_rd_q    <= op_rd_d;
            op_regwr_q <= op_regwr_d;
            op_load_q  <= op_load_d;
            op_store_q <= op_store_d;
            op_mis_q   <= op_mis_d;
            stall_q    <= stall_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_regwr_q <= wb_regwr_d;
            mis_err_q  <= mis_err_d;
        end
    end

    // Data memory write port
    always_ff @(posedge CLK) begin
        if (mem_we_s) begin
            mem_q[cmp_waddr_s] <= cmp_wdata_s;
        end
    end

    assign Stall       = stall_q;
    assign WbValid     = wb_valid_q;
    assign WbData      = wb_data_q;
    assign WbRdAddr    = wb_rd_q;
    assign WbRegWrite  = wb_regwr_q;
    assign MisalignErr = mis_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
//   Two instances: u_dut0 (WAIT_STATES=0), which is driven back-to-back from a
//   vector table and checked through an expected-result queue, and u_dut3
//   (WAIT_STATES=3), which is driven by hand-written multi-cycle sequences.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

    localparam logic [1:0] K_ALU = 2'd0;
    localparam logic [1:0] K_LW  = 2'd1;
    localparam logic [1:0] K_SW  = 2'd2;
    localparam logic [1:0] K_SWB = 2'd3;   // both strobes low

    typedef struct packed {
        logic        valid;
        logic        mem;
        logic        reb;
        logic        web;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rw;
    } drv_t;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] exp_data;
        logic        exp_rw;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    drv_t in0, in3;

    logic        stall0, wbv0, wbrw0, mis0;
    logic [31:0] wbd0;
    logic [4:0]  wbrd0;
    logic        stall3, wbv3, wbrw3, mis3;
    logic [31:0] wbd3;
    logic [4:0]  wbrd3;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp0_q[$];
    vec_t vecs[13];

    always #5 clk = ~clk;

    mem_access_stage #(.ADDR_W(10), .WAIT_STATES(0)) u_dut0 (
        .CLK(clk), .RSTB(rst_n), .InValid(in0.valid), .Dmem1ALUOUT(in0.mem),
        .DmemREB(in0.reb), .DmemWEB(in0.web), .ALUResult(in0.alu),
        .StoreData(in0.sd), .RdAddr(in0.rd), .RegWriteIn(in0.rw),
        .Stall(stall0), .WbValid(wbv0), .WbData(wbd0), .WbRdAddr(wbrd0),
        .WbRegWrite(wbrw0), .MisalignErr(mis0)
    );

    mem_access_stage #(.ADDR_W(10), .WAIT_STATES(3)) u_dut3 (
        .CLK(clk), .RSTB(rst_n), .InValid(in3.valid), .Dmem1ALUOUT(in3.mem),
        .DmemREB(in3.reb), .DmemWEB(in3.web), .ALUResult(in3.alu),
        .StoreData(in3.sd), .RdAddr(in3.rd), .RegWriteIn(in3.rw),
        .Stall(stall3), .WbValid(wbv3), .WbData(wbd3), .WbRdAddr(wbrd3),
        .WbRegWrite(wbrw3), .MisalignErr(mis3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [1:0] kind, input logic [31:0] alu,
                                 input logic [31:0] sd, input logic [4:0] rd, input logic rw,
                                 input logic [31:0] exp_data, input logic exp_rw);
        vec_t v;
        v.kind = kind; v.alu = alu; v.sd = sd; v.rd = rd; v.rw = rw;
        v.exp_data = exp_data; v.exp_rw = exp_rw;
        return v;
    endfunction

    function automatic drv_t mk(input vec_t v);
        drv_t d;
        d.valid = 1'b1;
        d.mem   = (v.kind != K_ALU);
        d.reb   = ~((v.kind == K_LW) || (v.kind == K_SWB));
        d.web   = ~((v.kind == K_SW) || (v.kind == K_SWB));
        d.alu   = v.alu;
        d.sd    = v.sd;
        d.rd    = v.rd;
        d.rw    = v.rw;
        return d;
    endfunction

    // Completion monitor for u_dut0: every WbValid pulse pops one expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && wbv0) begin
            if (exp0_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL dut0_unexpected: got WbValid=1 want no completion");
            end else begin
                e = exp0_q.pop_front();
                chk("dut0_data",  wbd0,  e.data);
                chk("dut0_rd",    32'(wbrd0), 32'(e.rd));
                chk("dut0_rw",    32'(wbrw0), 32'(e.rw));
                chk("dut0_stall", 32'(stall0), 32'd0);
                chk("dut0_mis",   32'(mis0),   32'd0);
            end
        end
    end

    // One op on u_dut3 with cycle-accurate checks of Stall and WbValid
    task automatic op3(input vec_t v, input logic exp_mis);
        @(negedge clk) in3 = mk(v);
        @(negedge clk);
        in3.valid = 1'b0;
        in3.alu   = ~v.alu;
        in3.sd    = ~v.sd;
        in3.rd    = ~v.rd;
        if (v.kind != K_ALU) begin
            for (int c = 1; c <= 3; c++) begin
                chk("dut3_wait_stall", 32'(stall3), 32'd1);
                chk("dut3_wait_valid", 32'(wbv3),   32'd0);
                @(negedge clk);
            end
        end
        chk("dut3_done_valid", 32'(wbv3),   32'd1);
        chk("dut3_done_stall", 32'(stall3), 32'd0);
        chk("dut3_data",       wbd3,        v.exp_data);
        chk("dut3_rd",         32'(wbrd3),  32'(v.rd));
        chk("dut3_rw",         32'(wbrw3),  32'(v.exp_rw));
        chk("dut3_mis",        32'(mis3),   32'(exp_mis));
        @(negedge clk);
        chk("dut3_after_valid", 32'(wbv3), 32'd0);
        chk("dut3_after_mis",   32'(mis3), 32'd0);
        chk("dut3_after_stall", 32'(stall3), 32'd0);
    endtask

    initial begin
        exp_t e;
        vecs[0]  = mkv(K_ALU, 32'h0000_1234, 32'h0,         5'd5,  1'b1, 32'h0000_1234, 1'b1);
        vecs[1]  = mkv(K_SW,  32'h0000_0010, 32'hDEAD_BEEF, 5'd0,  1'b0, 32'h0000_0010, 1'b0);
        vecs[2]  = mkv(K_LW,  32'h0000_0010, 32'hBAD0_BAD0, 5'd7,  1'b1, 32'hDEAD_BEEF, 1'b1);
        vecs[3]  = mkv(K_SW,  32'h1000_0004, 32'h0000_0055, 5'd3,  1'b1, 32'h1000_0004, 1'b0);
        vecs[4]  = mkv(K_LW,  32'h0000_0004, 32'h0,         5'd9,  1'b1, 32'h0000_0055, 1'b1);
        vecs[5]  = mkv(K_SWB, 32'h0000_0008, 32'hA5A5_0001, 5'd2,  1'b1, 32'h0000_0008, 1'b0);
        vecs[6]  = mkv(K_LW,  32'h0000_0008, 32'h0,         5'd4,  1'b1, 32'hA5A5_0001, 1'b1);
        vecs[7]  = mkv(K_ALU, 32'hFFFF_FFFF, 32'h0,         5'd31, 1'b0, 32'hFFFF_FFFF, 1'b0);
        vecs[8]  = mkv(K_SW,  32'h0000_0FFC, 32'h1234_5678, 5'd1,  1'b0, 32'h0000_0FFC, 1'b0);
        vecs[9]  = mkv(K_LW,  32'h0000_0FFC, 32'h0,         5'd6,  1'b1, 32'h1234_5678, 1'b1);
        vecs[10] = mkv(K_SW,  32'h0000_0000, 32'hCAFE_0000, 5'd0,  1'b0, 32'h0000_0000, 1'b0);
        vecs[11] = mkv(K_LW,  32'h0000_2000, 32'h0,         5'd8,  1'b1, 32'hCAFE_0000, 1'b1);
        vecs[12] = mkv(K_LW,  32'h0000_0010, 32'h0,         5'd30, 1'b0, 32'hDEAD_BEEF, 1'b0);

        rst_n = 1'b0;
        in0   = '0;
        in3   = '0;
        repeat (3) @(negedge clk);
        chk("rst0_valid", 32'(wbv0),   32'd0);
        chk("rst0_data",  wbd0,        32'd0);
        chk("rst0_rd",    32'(wbrd0),  32'd0);
        chk("rst0_rw",    32'(wbrw0),  32'd0);
        chk("rst0_stall", 32'(stall0), 32'd0);
        chk("rst0_mis",   32'(mis0),   32'd0);
        chk("rst3_valid", 32'(wbv3),   32'd0);
        chk("rst3_stall", 32'(stall3), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back table on the zero-wait instance
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (i > 0) chk("dut0_no_bubble", 32'(wbv0), 32'd1);
            in0 = mk(vecs[i]);
            e.data = vecs[i].exp_data;
            e.rd   = vecs[i].rd;
            e.rw   = vecs[i].exp_rw;
            exp0_q.push_back(e);
        end
        @(negedge clk);
        chk("dut0_last_valid", 32'(wbv0), 32'd1);
        in0 = '0;
        @(negedge clk);
        chk("dut0_idle_valid", 32'(wbv0), 32'd0);
        chk("dut0_idle_hold",  wbd0,      32'hDEAD_BEEF);

        // Three-wait-state instance
        op3(mkv(K_ALU, 32'h0000_ABCD, 32'h0,         5'd12, 1'b1, 32'h0000_ABCD, 1'b1), 1'b0);
        op3(mkv(K_SW,  32'h0000_0030, 32'h0BAD_F00D, 5'd0,  1'b0, 32'h0000_0030, 1'b0), 1'b0);
        op3(mkv(K_LW,  32'h0000_0030, 32'h0,         5'd7,  1'b1, 32'h0BAD_F00D, 1'b1), 1'b0);
        op3(mkv(K_SW,  32'h0000_0020, 32'h1111_0000, 5'd0,  1'b0, 32'h0000_0020, 1'b0), 1'b0);

        // Reset during the second WAIT cycle of a store to 0x20
        @(negedge clk) in3 = mk(mkv(K_SW, 32'h0000_0020, 32'h9999_9999, 5'd3, 1'b1, 32'h0, 1'b0));
        @(negedge clk);
        in3 = '0;
        chk("midrst_stall_c1", 32'(stall3), 32'd1);
        @(negedge clk);
        chk("midrst_stall_c2", 32'(stall3), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(wbv3),   32'd0);
        chk("midrst_data",  wbd3,        32'd0);
        chk("midrst_rd",    32'(wbrd3),  32'd0);
        chk("midrst_rw",    32'(wbrw3),  32'd0);
        chk("midrst_stall", 32'(stall3), 32'd0);
        chk("midrst_mis",   32'(mis3),   32'd0);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        op3(mkv(K_LW,  32'h0000_0020, 32'h0,         5'd10, 1'b1, 32'h1111_0000, 1'b1), 1'b0);

`ifdef MISALIGN_CHECK_EN
        op3(mkv(K_SW,  32'h0000_0022, 32'h7777_7777, 5'd4,  1'b1, 32'h0000_0022, 1'b0), 1'b1);
        op3(mkv(K_LW,  32'h0000_0020, 32'h0,         5'd11, 1'b1, 32'h1111_0000, 1'b1), 1'b0);
`endif

        @(negedge clk);
        chk("dut0_queue_empty", 32'(exp0_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
